// File: rtl/hls_init_pkg.sv
// hls_init_pkg: shared types and constants for the ap_ctrl_hs initiator.
//   state_t          controller states IDLE / RUN / RESP
//   DW_DEF           default scalar width
//   IO_B/O1_B/O0_B   bit positions in the capture mask and slot indices in
//                    the capture bank
//   NUM_CAP          number of captured output scalars
package hls_init_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DW_DEF  = 32;
    localparam int IO_B    = 2;
    localparam int O1_B    = 1;
    localparam int O0_B    = 0;
    localparam int NUM_CAP = 3;

endpackage

// File: rtl/hls_init_capture.sv
// hls_init_capture: ap_vld-qualified register bank with a per-slot "written" mask.
//   clk, rst      clock, asynchronous active-high reset
//   load_i        preload every slot from load_val_i and clear the mask
//   load_val_i    preload values, slot k at [k*DW +: DW]
//   wr_en_i       per-slot write strobe (ap_vld already qualified by caller)
//   wr_dat_i      per-slot write data
//   q_o           current slot values
//   mask_o        slot k written since the last load
module hls_init_capture #(
    parameter int DW = 32,
    parameter int N  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [N*DW-1:0] load_val_i,
    input  logic [N-1:0]    wr_en_i,
    input  logic [N*DW-1:0] wr_dat_i,
    output logic [N*DW-1:0] q_o,
    output logic [N-1:0]    mask_o
);

    logic [N*DW-1:0] q_q, q_d;
    logic [N-1:0]    mask_q, mask_d;

    // A write in a later cycle simply overwrites: the last value wins.
    always_comb begin
        q_d    = q_q;
        mask_d = mask_q;
        if (load_i) begin
            q_d    = load_val_i;
            mask_d = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_en_i[i]) begin
                    q_d[i*DW +: DW] = wr_dat_i[i*DW +: DW];
                    mask_d[i]       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            mask_q <= '0;
        end else begin
            q_q    <= q_d;
            mask_q <= mask_d;
        end
    end

    assign q_o    = q_q;
    assign mask_o = mask_q;

endmodule

// File: rtl/hls_ap_ctrl_initiator.sv
// hls_ap_ctrl_initiator: ap_ctrl_hs block-level initiator for one HLS kernel.
// Takes one operand bundle per command, runs one kernel call (start held until
// ap_ready), captures ap_vld outputs, the in/out scalar and ap_return, and
// returns them on a valid/ready response port. A call that runs TIMEOUT_CYC
// RUN cycles without ap_done is aborted (TIMEOUT_CYC = 0 disables this).
//   ap_clk, ap_rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_args/cmd_io_init   command port
//   k_ap_start/done/idle/ready      kernel block-level handshake
//   k_args                          registered kernel arguments
//   k_o0/k_o1 (+_vld)               kernel output scalars
//   k_io_i, k_io_o (+_vld)          in/out scalar read / write sides
//   k_ap_return                     kernel return value
//   rsp_valid/rsp_ready/rsp_*       response port
//   busy                            controller not idle
// Optional build macro HLS_INIT_CYCLE_STATS_EN adds rsp_cycles (RUN cycles of
// the call, saturating) and stat_calls (completed non-timeout calls, wrapping).
module hls_ap_ctrl_initiator
    import hls_init_pkg::*;
#(
    parameter int NUM_IN      = 20,
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [NUM_IN*DW-1:0] cmd_args,
    input  logic [DW-1:0]        cmd_io_init,
    output logic                 k_ap_start,
    input  logic                 k_ap_done,
    input  logic                 k_ap_idle,
    input  logic                 k_ap_ready,
    output logic [NUM_IN*DW-1:0] k_args,
    input  logic [DW-1:0]        k_o0,
    input  logic                 k_o0_vld,
    input  logic [DW-1:0]        k_o1,
    input  logic                 k_o1_vld,
    output logic [DW-1:0]        k_io_i,
    input  logic [DW-1:0]        k_io_o,
    input  logic                 k_io_o_vld,
    input  logic [DW-1:0]        k_ap_return,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_ret,
    output logic [DW-1:0]        rsp_o0,
    output logic [DW-1:0]        rsp_o1,
    output logic [DW-1:0]        rsp_io,
    output logic [2:0]           rsp_vld_mask,
    output logic                 rsp_timeout,
    output logic                 busy
`ifdef HLS_INIT_CYCLE_STATS_EN
    ,
    output logic [15:0]          rsp_cycles,
    output logic [31:0]          stat_calls
`endif
);

    localparam logic [31:0] TO_LAST = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t                state_q;
    logic                  start_q;
    logic                  rsp_valid_q;
    logic                  rsp_timeout_q;
    logic [NUM_IN*DW-1:0]  args_q;
    logic [DW-1:0]         ret_q;
    logic [31:0]           to_cnt_q;

    logic                  accept;
    logic                  in_run;
    logic                  timeout_hit;
    logic [NUM_CAP-1:0]    cap_wr_en;
    logic [NUM_CAP-1:0]    cap_mask;
    logic [NUM_CAP*DW-1:0] cap_load_val;
    logic [NUM_CAP*DW-1:0] cap_wr_dat;
    logic [NUM_CAP*DW-1:0] cap_q;

    assign accept = (state_q == IDLE) && k_ap_idle && cmd_valid;
    assign in_run = (state_q == RUN);
    // to_cnt_q counts completed RUN cycles, so equality with TO_LAST marks the
    // TIMEOUT_CYC-th RUN cycle. A done in that same cycle still wins.
    assign timeout_hit = (TIMEOUT_CYC > 0) && (to_cnt_q == TO_LAST);

    // The in/out slot preloads with the command's initial value; the pure
    // outputs start from zero.
    always_comb begin
        cap_load_val                  = '0;
        cap_load_val[IO_B*DW +: DW]   = cmd_io_init;
        cap_wr_dat                    = '0;
        cap_wr_dat[O0_B*DW +: DW]     = k_o0;
        cap_wr_dat[O1_B*DW +: DW]     = k_o1;
        cap_wr_dat[IO_B*DW +: DW]     = k_io_o;
        cap_wr_en                     = '0;
        cap_wr_en[O0_B]               = in_run && k_o0_vld;
        cap_wr_en[O1_B]               = in_run && k_o1_vld;
        cap_wr_en[IO_B]               = in_run && k_io_o_vld;
    end

    hls_init_capture #(
        .DW (DW),
        .N  (NUM_CAP)
    ) u_capture (
        .clk        (ap_clk),
        .rst        (ap_rst),
        .load_i     (accept),
        .load_val_i (cap_load_val),
        .wr_en_i    (cap_wr_en),
        .wr_dat_i   (cap_wr_dat),
        .q_o        (cap_q),
        .mask_o     (cap_mask)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            args_q        <= '0;
            ret_q         <= '0;
            to_cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        args_q   <= cmd_args;
                        ret_q    <= '0;
                        to_cnt_q <= '0;
                        start_q  <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    to_cnt_q <= to_cnt_q + 32'd1;
                    // Hold start until the kernel has taken it (ap_ctrl_hs).
                    if (k_ap_ready) begin
                        start_q <= 1'b0;
                    end
                    if (k_ap_done) begin
                        ret_q       <= k_ap_return;
                        start_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        ret_q         <= '0;
                        start_q       <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef HLS_INIT_CYCLE_STATS_EN
    logic [15:0] cycles_q;
    logic [31:0] calls_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cycles_q <= '0;
            calls_q  <= '0;
        end else begin
            if (accept) begin
                cycles_q <= '0;
            end else if (in_run && (cycles_q != 16'hFFFF)) begin
                cycles_q <= cycles_q + 16'd1;
            end
            if (in_run && k_ap_done) begin
                calls_q <= calls_q + 32'd1;
            end
        end
    end

    assign rsp_cycles = cycles_q;
    assign stat_calls = calls_q;
`endif

    assign cmd_ready    = (state_q == IDLE) && k_ap_idle;
    assign k_ap_start   = start_q;
    assign k_args       = args_q;
    assign k_io_i       = cap_q[IO_B*DW +: DW];
    assign rsp_valid    = rsp_valid_q;
    assign rsp_ret      = ret_q;
    assign rsp_o0       = cap_q[O0_B*DW +: DW];
    assign rsp_o1       = cap_q[O1_B*DW +: DW];
    assign rsp_io       = cap_q[IO_B*DW +: DW];
    assign rsp_vld_mask = cap_mask;
    assign rsp_timeout  = rsp_timeout_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hls_ap_ctrl_initiator.sv
// tb_hls_ap_ctrl_initiator: bench for hls_ap_ctrl_initiator. A scripted kernel
// raises ready/done/vld at chosen RUN-cycle offsets; the expected response is
// derived from the script (last write wins, in/out value seen at done, timeout
// after TO RUN cycles). Define HLS_INIT_CYCLE_STATS_EN to cover the stats ports.
module tb_hls_ap_ctrl_initiator;

    localparam int NUM_IN = 20;
    localparam int DW     = 32;
    localparam int TO     = 16;
    localparam int MAXT   = 40;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [NUM_IN*DW-1:0] cmd_args;
    logic [DW-1:0]        cmd_io_init;
    logic                 k_ap_start;
    logic                 k_ap_done;
    logic                 k_ap_idle;
    logic                 k_ap_ready;
    logic [NUM_IN*DW-1:0] k_args;
    logic [DW-1:0]        k_o0;
    logic                 k_o0_vld;
    logic [DW-1:0]        k_o1;
    logic                 k_o1_vld;
    logic [DW-1:0]        k_io_i;
    logic [DW-1:0]        k_io_o;
    logic                 k_io_o_vld;
    logic [DW-1:0]        k_ap_return;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [DW-1:0]        rsp_ret;
    logic [DW-1:0]        rsp_o0;
    logic [DW-1:0]        rsp_o1;
    logic [DW-1:0]        rsp_io;
    logic [2:0]           rsp_vld_mask;
    logic                 rsp_timeout;
    logic                 busy;
`ifdef HLS_INIT_CYCLE_STATS_EN
    logic [15:0]          rsp_cycles;
    logic [31:0]          stat_calls;
`endif

    hls_ap_ctrl_initiator #(
        .NUM_IN      (NUM_IN),
        .DW          (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_args     (cmd_args),
        .cmd_io_init  (cmd_io_init),
        .k_ap_start   (k_ap_start),
        .k_ap_done    (k_ap_done),
        .k_ap_idle    (k_ap_idle),
        .k_ap_ready   (k_ap_ready),
        .k_args       (k_args),
        .k_o0         (k_o0),
        .k_o0_vld     (k_o0_vld),
        .k_o1         (k_o1),
        .k_o1_vld     (k_o1_vld),
        .k_io_i       (k_io_i),
        .k_io_o       (k_io_o),
        .k_io_o_vld   (k_io_o_vld),
        .k_ap_return  (k_ap_return),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_ret      (rsp_ret),
        .rsp_o0       (rsp_o0),
        .rsp_o1       (rsp_o1),
        .rsp_io       (rsp_io),
        .rsp_vld_mask (rsp_vld_mask),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
`ifdef HLS_INIT_CYCLE_STATS_EN
        ,
        .rsp_cycles   (rsp_cycles),
        .stat_calls   (stat_calls)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_calls = 0;

    // Kernel script for one call: per RUN cycle t, which outputs are written.
    logic [2:0]    sc_vld [1:MAXT];
    logic [DW-1:0] sc_dat [1:MAXT][0:2];
    int            sc_rdy;
    int            sc_done;
    int            sc_bp;
    logic [DW-1:0] sc_init;
    logic [DW-1:0] sc_off;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic clear_script();
        for (int t = 1; t <= MAXT; t++) begin
            sc_vld[t] = 3'b000;
            for (int k = 0; k < 3; k++) sc_dat[t][k] = $urandom;
        end
        sc_rdy  = 1;
        sc_done = 1;
        sc_bp   = 0;
        sc_init = $urandom;
        sc_off  = $urandom;
    endtask

    task automatic random_script();
        clear_script();
        for (int t = 1; t <= MAXT; t++)
            for (int k = 0; k < 3; k++) sc_vld[t][k] = ($urandom_range(0, 3) == 0);
        sc_rdy  = $urandom_range(1, 5);
        sc_done = ($urandom_range(0, 7) == 0) ? 0 : sc_rdy + $urandom_range(0, 6);
        sc_bp   = $urandom_range(0, 3);
    endtask

    task automatic kernel_quiet();
        k_ap_ready  = 1'b0;
        k_ap_done   = 1'b0;
        k_o0_vld    = 1'b0;
        k_o1_vld    = 1'b0;
        k_io_o_vld  = 1'b0;
        k_ap_return = $urandom;
    endtask

    // Called at a falling edge with the controller idle; returns at a falling
    // edge with the controller idle again.
    task automatic run_call();
        logic [NUM_IN*DW-1:0] args;
        logic [DW-1:0]        exp_v [0:2];
        logic [2:0]           exp_m;
        logic [DW-1:0]        io_seen;
        logic [DW-1:0]        exp_ret;
        logic                 to;
        int                   last_t;
        int                   hi_t;

        // Reference: outcome of the call from the script alone.
        to     = (sc_done == 0);
        last_t = to ? TO : sc_done;
        hi_t   = (sc_rdy != 0 && sc_rdy <= last_t) ? sc_rdy : last_t;
        exp_v[0] = '0;
        exp_v[1] = '0;
        exp_v[2] = sc_init;
        exp_m    = 3'b000;
        io_seen  = sc_init;
        for (int t = 1; t <= last_t; t++)
            for (int k = 0; k < 3; k++)
                if (sc_vld[t][k]) begin
                    exp_v[k] = sc_dat[t][k];
                    exp_m[k] = 1'b1;
                    if (k == 2 && t < last_t) io_seen = sc_dat[t][k];
                end
        exp_ret = to ? '0 : io_seen + sc_off;
        if (!to) exp_calls++;

        for (int i = 0; i < NUM_IN; i++) args[i*DW +: DW] = $urandom;
        cmd_args    = args;
        cmd_io_init = sc_init;
        cmd_valid   = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);

        for (int t = 1; t <= last_t; t++) begin
            @(negedge ap_clk);
            if (t == 1) begin
                cmd_valid = 1'b0;
                check("k_args", k_args == args, 1);
                check("k_io_i_init", k_io_i, sc_init);
            end
            check("k_ap_start", k_ap_start, t <= hi_t);
            check("busy_run", busy, 1);
            check("cmd_ready_run", cmd_ready, 0);
            check("rsp_valid_run", rsp_valid, 0);
            k_ap_ready  = (t == sc_rdy);
            k_ap_done   = (t == sc_done);
            k_o0_vld    = sc_vld[t][0];
            k_o1_vld    = sc_vld[t][1];
            k_io_o_vld  = sc_vld[t][2];
            k_o0        = sc_dat[t][0];
            k_o1        = sc_dat[t][1];
            k_io_o      = sc_dat[t][2];
            k_ap_return = (t == sc_done) ? k_io_i + sc_off : $urandom;
        end

        @(negedge ap_clk);
        kernel_quiet();
        k_o0_vld  = 1'b1;  // ignored outside RUN
        cmd_valid = 1'b1;  // offered while the response is held
        cmd_args  = ~args;
        for (int b = 0; b <= sc_bp; b++) begin
            if (b > 0) @(negedge ap_clk);
            check("rsp_valid", rsp_valid, 1);
            check("rsp_timeout", rsp_timeout, to);
            check("rsp_ret", rsp_ret, exp_ret);
            check("rsp_o0", rsp_o0, exp_v[0]);
            check("rsp_o1", rsp_o1, exp_v[1]);
            check("rsp_io", rsp_io, exp_v[2]);
            check("rsp_vld_mask", rsp_vld_mask, exp_m);
            check("start_resp", k_ap_start, 0);
            check("cmd_ready_resp", cmd_ready, 0);
            check("k_args_hold", k_args == args, 1);
`ifdef HLS_INIT_CYCLE_STATS_EN
            check("rsp_cycles", rsp_cycles, last_t);
            check("stat_calls", stat_calls, exp_calls);
`endif
            rsp_ready = (b == sc_bp);
        end
        @(negedge ap_clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        k_o0_vld  = 1'b0;
        check("rsp_valid_after", rsp_valid, 0);
        check("rsp_timeout_after", rsp_timeout, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stray;
        ap_rst      = 1'b1;
        cmd_valid   = 1'b0;
        cmd_args    = '0;
        cmd_io_init = '0;
        k_ap_idle   = 1'b1;
        rsp_ready   = 1'b0;
        k_o0 = '0; k_o1 = '0; k_io_o = '0;
        kernel_quiet();
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_start", k_ap_start, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_mask", rsp_vld_mask, 0);
        check("rst_ret", rsp_ret, 0);
        check("rst_io", k_io_i, 0);
        check("rst_args_zero", k_args == '0, 1);
`ifdef HLS_INIT_CYCLE_STATS_EN
        check("rst_stat_calls", stat_calls, 0);
`endif

        // Kernel not idle: no accept.
        k_ap_idle = 1'b0;
        cmd_valid = 1'b1;
        #1 check("cmd_ready_not_idle", cmd_ready, 0);
        @(negedge ap_clk);
        check("no_accept_not_idle", busy, 0);
        cmd_valid = 1'b0;
        k_ap_idle = 1'b1;

        // Spurious done while idle.
        k_ap_done = 1'b1;
        @(negedge ap_clk);
        k_ap_done = 1'b0;
        check("spurious_done_busy", busy, 0);
        check("spurious_done_rsp", rsp_valid, 0);

        // 1-cycle kernel: o0 written in the start cycle.
        clear_script();
        sc_rdy = 2; sc_done = 2; sc_init = '0; sc_off = 32'h0000_1234;
        sc_vld[1] = 3'b001; sc_dat[1][0] = 32'h0000_00A5;
        run_call();

        // In/out scalar: init 7, kernel writes 9, returns k_io_i + 1.
        clear_script();
        sc_rdy = 2; sc_done = 2; sc_init = 32'd7; sc_off = 32'd1;
        sc_vld[1] = 3'b100; sc_dat[1][2] = 32'd9;
        run_call();

        // Slow kernel: ready after 4 cycles, done at 6.
        clear_script();
        sc_rdy = 4; sc_done = 6;
        sc_vld[3] = 3'b010; sc_vld[6] = 3'b011;
        run_call();

        // Kernel never ready nor done: timeout.
        clear_script();
        sc_rdy = 0; sc_done = 0;
        sc_vld[5] = 3'b100;
        run_call();

        // Response backpressure with a command waiting; io overwritten twice.
        clear_script();
        sc_rdy = 2; sc_done = 3; sc_bp = 5;
        sc_vld[1] = 3'b100; sc_vld[2] = 3'b100;
        run_call();

        // Randomized calls.
        for (int n = 0; n < 25; n++) begin
            random_script();
            run_call();
        end

        // Reset in the middle of a call.
        cmd_args    = {NUM_IN{32'hDEAD_BEEF}};
        cmd_io_init = 32'd3;
        cmd_valid   = 1'b1;
        @(negedge ap_clk);
        cmd_valid = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        check("start_before_rst", k_ap_start, 1);
        #2 ap_rst = 1'b1;
        #1;
        check("async_rst_start", k_ap_start, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_args", k_args == '0, 1);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        exp_calls = 0;
        stray = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge ap_clk);
            if (rsp_valid || busy) stray++;
        end
        check("no_rsp_after_rst", stray, 0);

        // The block is usable again after the interrupted call.
        random_script();
        sc_done = sc_rdy;
        run_call();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
